// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/response bundle between the fetch unit (master) and memory (slave).
interface ifu_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding request, holds the fetched word until downstream accepts it.
// Define IFU_ADDR_CHECK_EN to raise AdEL (code 4) for misaligned or out-of-range fetch addresses.
module ifu_fetch #(
  parameter logic [31:0] PC_INIT = 32'h0000_3000,
  parameter logic [31:0] IM_BASE = 32'h0000_3000,
  parameter logic [31:0] IM_END  = 32'h0000_6FFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      NPC,
  input  logic             Stall,
  input  logic             Req,
  output logic [31:0]      PC,
  ifu_fetch_if.master      imem,
  output logic             F_Valid,
  output logic [31:0]      F_Instr,
  output logic [4:0]       F_ExcCode
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  localparam logic [4:0] EXC_ADEL = 5'd4;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [4:0]  exc_q, exc_d;

  logic addr_bad;
  logic addr_exc;

  assign addr_bad = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_END);

`ifdef IFU_ADDR_CHECK_EN
  assign addr_exc = addr_bad;
`else
  logic unused_addr_bad;
  assign unused_addr_bad = addr_bad;
  assign addr_exc = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= PC_INIT;
      instr_q <= 32'h0;
      exc_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    exc_d   = exc_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (addr_exc) begin
          // Nothing is outstanding on the bus, so a redirect simply retries at the new PC.
          if (Req) begin
            pc_d = NPC;
          end else begin
            instr_d = 32'h0;
            exc_d   = EXC_ADEL;
            state_d = HOLD;
          end
        end else if (imem.imem_ack) begin
          if (Req) begin
            pc_d = NPC;
          end else begin
            instr_d = imem.imem_rdata;
            exc_d   = 5'd0;
            state_d = HOLD;
          end
        end else if (Req) begin
          // The request is still in flight; its ack must be swallowed before refetching.
          pc_d    = NPC;
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (Req || !Stall) begin
          pc_d    = NPC;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (Req) begin
          pc_d = NPC;
        end
        if (imem.imem_ack) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem.imem_req  = (state_q == FETCH) && !addr_exc;
  assign imem.imem_addr = pc_q;
  assign PC             = pc_q;
  assign F_Valid        = (state_q == HOLD);
  assign F_Instr        = instr_q;
  assign F_ExcCode      = exc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: lockstep reference model plus a scoreboard of presented instructions.
module tb_ifu_fetch;

  localparam logic [31:0] PC_INIT = 32'h0000_3000;
  localparam logic [31:0] IM_BASE = 32'h0000_3000;
  localparam logic [31:0] IM_END  = 32'h0000_6FFF;
`ifdef IFU_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] NPC;
  logic        Stall;
  logic        Req;
  logic [31:0] PC;
  logic        F_Valid;
  logic [31:0] F_Instr;
  logic [4:0]  F_ExcCode;

  ifu_fetch_if imem();

  ifu_fetch #(.PC_INIT(PC_INIT), .IM_BASE(IM_BASE), .IM_END(IM_END)) dut (
    .clk       (clk),
    .reset     (reset),
    .NPC       (NPC),
    .Stall     (Stall),
    .Req       (Req),
    .PC        (PC),
    .imem      (imem),
    .F_Valid   (F_Valid),
    .F_Instr   (F_Instr),
    .F_ExcCode (F_ExcCode)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
  } pres_t;

  pres_t exp_q[$];

  // Reference model: what the fetch unit is doing after the coming edge.
  bit          m_idle, m_present, m_orphan;
  logic [31:0] m_pc;

  // Memory partner state.
  bit          mem_busy;
  int          mem_left;
  logic [31:0] mem_addr;

  // Stimulus knobs.
  int k_wait, k_req_pct, k_stall_pct, k_spur_pct;
  bit k_seq;

  function automatic bit bad_addr(input logic [31:0] a);
    return CHECK_EN && ((a[1:0] != 2'b00) || (a < IM_BASE) || (a > IM_END));
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h2408_0001;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] rand_npc();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 32'h0000_3002;
    if (r == 1) return 32'h0000_7000 + 32'($urandom_range(0, 255) * 4);
    return IM_BASE + 32'($urandom_range(0, 32'hFFF) * 4);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops an expectation on each new presentation, checks stability while held.
  bit    mon_prev = 1'b0;
  pres_t mon_cur;
  always @(negedge clk) begin
    if (reset) begin
      mon_prev = 1'b0;
    end else begin
      if (F_Valid && !mon_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_instr: got %h at pc %h, expected no presentation", F_Instr, PC);
          mon_cur = '{pc: PC, instr: F_Instr, exc: F_ExcCode};
        end else begin
          mon_cur = exp_q.pop_front();
          check32("sb_pc", PC, mon_cur.pc);
        end
      end
      if (F_Valid) begin
        check32("sb_instr", F_Instr, mon_cur.instr);
        check32("sb_exc", {27'd0, F_ExcCode}, {27'd0, mon_cur.exc});
      end
      mon_prev = F_Valid;
    end
  end

  // One cycle of lockstep checks, memory response, stimulus and model advance.
  task automatic step();
    bit ack;
    bit exc;
    check32("pc", PC, m_pc);
    check32("imem_addr", imem.imem_addr, m_pc);
    check32("imem_req", {31'd0, imem.imem_req},
            {31'd0, !m_idle && !m_present && !m_orphan && !bad_addr(m_pc)});
    check32("f_valid", {31'd0, F_Valid}, {31'd0, m_present});

    ack = 1'b0;
    imem.imem_rdata = 32'hDEAD_0000 | 32'($urandom_range(0, 65535));
    if (!mem_busy && imem.imem_req) begin
      mem_busy = 1'b1;
      mem_addr = imem.imem_addr;
      mem_left = (k_wait < 0) ? $urandom_range(0, 3) : k_wait;
    end
    if (mem_busy) begin
      if (mem_left == 0) begin
        ack = 1'b1;
        imem.imem_rdata = mem_word(mem_addr);
        mem_busy = 1'b0;
      end else begin
        mem_left--;
      end
    end else if (!imem.imem_req && $urandom_range(0, 99) < k_spur_pct) begin
      ack = 1'b1;
    end
    imem.imem_ack = ack;

    Req   = ($urandom_range(0, 99) < k_req_pct);
    Stall = ($urandom_range(0, 99) < k_stall_pct);
    NPC   = k_seq ? m_pc + 32'd4 : rand_npc();

    exc = bad_addr(m_pc);
    if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_present) begin
      if (Req || !Stall) begin
        m_present = 1'b0;
        m_pc = NPC;
      end
    end else if (m_orphan) begin
      if (Req) m_pc = NPC;
      if (ack) m_orphan = 1'b0;
    end else if (exc) begin
      if (Req) m_pc = NPC;
      else begin
        m_present = 1'b1;
        exp_q.push_back('{pc: m_pc, instr: 32'h0, exc: 5'd4});
      end
    end else if (ack) begin
      if (Req) m_pc = NPC;
      else begin
        m_present = 1'b1;
        exp_q.push_back('{pc: m_pc, instr: imem.imem_rdata, exc: 5'd0});
      end
    end else if (Req) begin
      m_pc = NPC;
      m_orphan = 1'b1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    step();
  endtask

  // Asserts reset at the current time, checks the asynchronous effect, then releases on a negedge.
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check32("rst_pc", PC, PC_INIT);
    check32("rst_req", {31'd0, imem.imem_req}, 32'd0);
    check32("rst_valid", {31'd0, F_Valid}, 32'd0);
    check32("rst_instr", F_Instr, 32'd0);
    check32("rst_exc", {27'd0, F_ExcCode}, 32'd0);
    exp_q.delete();
    mem_busy = 1'b0;
    imem.imem_ack = 1'b0;
    imem.imem_rdata = 32'h0;
    Req = 1'b0;
    Stall = 1'b0;
    NPC = PC_INIT;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_idle = 1'b1;
    m_present = 1'b0;
    m_orphan = 1'b0;
    m_pc = PC_INIT;
    step();
  endtask

  task automatic set_knobs(input int w, input int rq, input int st, input int sp, input bit sq);
    k_wait = w;
    k_req_pct = rq;
    k_stall_pct = st;
    k_spur_pct = sp;
    k_seq = sq;
  endtask

  initial begin
    bit found;
    set_knobs(0, 0, 0, 0, 1'b1);
    apply_reset();

    // Zero-wait fetch from reset: instruction visible two cycles after release, then PC advances.
    cycle();
    cycle();
    check32("boot_valid", {31'd0, F_Valid}, 32'd1);
    check32("boot_instr", F_Instr, 32'h2408_0001);
    cycle();
    check32("boot_next_pc", PC, 32'h0000_3004);
    repeat (6) cycle();

    set_knobs(3, 0, 0, 0, 1'b1);
    repeat (20) cycle();

    set_knobs(-1, 0, 70, 20, 1'b1);
    repeat (60) cycle();

    set_knobs(-1, 15, 40, 10, 1'b0);
    repeat (3000) cycle();

    // Reset while draining an abandoned request.
    set_knobs(3, 40, 20, 0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      cycle();
      if (m_orphan) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL drain_reach: got no DRAIN within 2000 cycles, expected one");
    end else begin
      @(posedge clk);
      #2;
      check32("drain_req", {31'd0, imem.imem_req}, 32'd0);
      apply_reset();
    end

    set_knobs(-1, 15, 40, 10, 1'b0);
    repeat (1000) cycle();

    @(negedge clk);
    n_cmp++;
    if (exp_q.size() > 1) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending expectations, expected at most 1", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL provide parameter PC_INIT, default 32'h0000_3000, the PC value loaded at reset.
REQ-002 SHALL provide parameter IM_BASE, default 32'h0000_3000, the lowest legal fetch address.
REQ-003 SHALL provide parameter IM_END, default 32'h0000_6FFF, the highest legal fetch byte address.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port NPC, input, 32 bits: next PC from the next-PC logic (already includes the Req/ERET selection).
REQ-007 SHALL have port Stall, input, 1 bit: downstream is not ready to accept the held instruction.
REQ-008 SHALL have port Req, input, 1 bit: exception/interrupt redirect; it flushes the fetch and loads NPC.
REQ-009 SHALL have port PC, output, 32 bits: the current fetch address, which feeds next-PC logic and the ID stage.
REQ-010 SHALL have port imem_req, output, 1 bit, and port imem_addr, output, 32 bits: the instruction-memory request.
REQ-011 SHALL have port imem_ack, input, 1 bit, and port imem_rdata, input, 32 bits: the memory response.
REQ-012 SHALL have port F_Valid, output, 1 bit; port F_Instr, output, 32 bits; and port F_ExcCode, output, 5 bits: the fetched instruction handed downstream.

Function
REQ-013 SHALL implement an FSM with states IDLE, FETCH, HOLD and DRAIN.
REQ-014 SHALL drive imem_addr = PC at all times; imem_req SHALL be 1 only in FETCH with no address exception, and SHALL remain high with a stable address until imem_ack.
REQ-015 IDLE SHALL transition to FETCH unconditionally on the next edge, with PC unchanged.
REQ-016 In FETCH with imem_ack=1 and Req=0, the block SHALL latch imem_rdata into F_Instr, set F_ExcCode=0 and go to HOLD.
REQ-017 In FETCH with an address exception (PC[1:0]!=0, PC<IM_BASE or PC>IM_END), the block SHALL issue no request, set F_Instr=0 and F_ExcCode=5'd4 (AdEL), and go to HOLD next cycle.
REQ-018 In FETCH with Req=1 and imem_ack=0, the block SHALL load PC<=NPC and go to DRAIN.
REQ-019 In FETCH with Req=1 and imem_ack=1, the block SHALL discard the data, load PC<=NPC and stay in FETCH.
REQ-020 F_Valid SHALL equal 1 exactly in HOLD, and F_Instr and F_ExcCode SHALL stay stable throughout HOLD.
REQ-021 In HOLD with Req=1 (regardless of Stall), or with Req=0 and Stall=0, the block SHALL load PC<=NPC and go to FETCH.
REQ-022 In HOLD with Req=0 and Stall=1, the block SHALL hold all state.
REQ-023 In DRAIN, imem_req SHALL be 0; on imem_ack the data SHALL be dropped and the FSM SHALL go to FETCH.
REQ-024 In DRAIN, Req=1 SHALL reload PC<=NPC; if imem_ack is also 1 that cycle, the FSM SHALL go to FETCH, otherwise it SHALL stay in DRAIN.
REQ-025 An imem_ack in IDLE or HOLD SHALL be ignored.
REQ-026 Minimum latency SHALL be: request asserted in cycle n with ack in cycle n gives F_Valid=1 in cycle n+1, for a peak throughput of one instruction per 2 cycles.
REQ-027 The PC SHALL be a full 32-bit register loaded only from NPC or PC_INIT, with no internal arithmetic.

Reset
REQ-028 While reset=1, the block SHALL force state=IDLE, PC=PC_INIT, F_Valid=0, F_Instr=0, F_ExcCode=0 and imem_req=0 asynchronously.
REQ-029 Reset asserted mid-fetch SHALL abandon the outstanding request, and an ack arriving in IDLE SHALL be ignored.

Configuration
REQ-030 Macro IFU_ADDR_CHECK_EN SHALL control address checking: when defined, REQ-017 is active; when undefined, every PC is requested from memory and F_ExcCode is constant 0.

Verification
REQ-031 Reset, zero-wait memory returning 32'h2408_0001 at 32'h3000, NPC=PC+4 -> F_Valid=1 with F_Instr=32'h2408_0001 in cycle 2, then PC=32'h3004.
REQ-032 Memory with 3 wait cycles -> imem_req held high with imem_addr stable for 4 cycles, and F_Valid asserted 1 cycle after ack.
REQ-033 HOLD with Stall=1 for 5 cycles -> PC, F_Instr and F_Valid unchanged; Stall=0 -> PC<=NPC next edge.
REQ-034 Req=1 with NPC=32'h4180 during a pending fetch, ack 2 cycles later -> the late data is never presented, and the next imem_addr is 32'h4180.
REQ-035 With IFU_ADDR_CHECK_EN, PC=32'h3002 -> imem_req=0, F_Valid=1, F_ExcCode=4, F_Instr=0; without the macro -> a request is issued to 32'h3002.
REQ-036 Reset asserted in the middle of DRAIN -> outputs return immediately to their reset values, with PC=32'h3000.
